// File: rtl/eu_fetch_sched.sv
// eu_fetch_sched: walks a mask of EU sub-units in ascending order, issuing
// one fetch command per sub-unit and waiting for its completion pulse (or a
// timeout) before moving on to the next address.
module eu_fetch_sched #(
  parameter int NUM_SUB = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NUM_SUB-1:0] fetch_mask,
  input  logic [31:0]        base_addr,
  input  logic [31:0]        stride,
  input  logic [NUM_SUB-1:0] sub_done,
  output logic [NUM_SUB-1:0] eu_fetch,
  output logic [31:0]        eu_fetch_addr,
  output logic [4:0]         sdram_read_sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Counter is wide enough to hold TIMEOUT-1; it never counts past that.
  localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [NUM_SUB-1:0] pending;
  logic [NUM_SUB-1:0] cur_bit;
  logic [NUM_SUB-1:0] pending_left;
  logic [31:0]        addr;
  logic [31:0]        stride_q;
  logic [4:0]         idx;
  logic [CW-1:0]      wait_cnt;
  logic               hit;
  logic               timeout_hit;
  logic               advance;
  logic               active;

  // Isolate the lowest pending bit; pending is unchanged from ISSUE through
  // WAIT, so this also serves as the held selection for the whole slot.
  assign cur_bit      = pending & (~pending + NUM_SUB'(1));
  assign pending_left = pending & ~cur_bit;
  assign active       = (state == ISSUE) || (state == WAIT);
  assign hit          = (state == WAIT) && (|(sub_done & cur_bit));
  assign timeout_hit  = (state == WAIT) && (TIMEOUT != 0) && (wait_cnt == TO_LAST);
  assign advance      = hit || timeout_hit;

  // Binary index of the lowest pending bit (highest index loses priority).
  always_comb begin
    idx = '0;
    for (int i = NUM_SUB - 1; i >= 0; i--) begin
      if (pending[i]) idx = 5'(i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the state-derived outputs.
  always_comb begin
    state_nxt      = state;
    eu_fetch       = '0;
    eu_fetch_addr  = '0;
    sdram_read_sel = '0;
    busy           = 1'b0;
    done           = 1'b0;
    if (active) begin
      eu_fetch_addr  = addr;
      sdram_read_sel = idx;
    end
    case (state)
      IDLE: begin
        if (start) state_nxt = (fetch_mask != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        busy      = 1'b1;
        eu_fetch  = cur_bit;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (advance) state_nxt = (pending_left != '0) ? ISSUE : DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence datapath: latch the request, step address and pending mask on
  // each completion or timeout, and keep the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      addr     <= '0;
      stride_q <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pending  <= fetch_mask;
            addr     <= base_addr;
            stride_q <= stride;
            err      <= 1'b0;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
        end
        WAIT: begin
          if (advance) begin
            pending <= pending_left;
            addr    <= addr + stride_q;
            if (!hit) err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eu_fetch_sched.sv
// Testbench for eu_fetch_sched: a timeline model built from the sequencing
// rules predicts every output cycle by cycle for directed and random runs.
module tb_eu_fetch_sched;

  localparam int NS   = 8;
  localparam int TO   = 16;
  localparam int MAXC = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  fetch_mask;
  logic [31:0] base_addr;
  logic [31:0] stride;
  logic [7:0]  sub_done;
  logic [7:0]  eu_fetch;
  logic [31:0] eu_fetch_addr;
  logic [4:0]  sdram_read_sel;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int dly[NS];

  logic [7:0]  e_fetch[MAXC];
  logic [31:0] e_addr[MAXC];
  logic [4:0]  e_sel[MAXC];
  logic [7:0]  e_sd[MAXC];
  bit          e_act[MAXC];
  bit          e_busy[MAXC];
  bit          e_done[MAXC];
  bit          e_err[MAXC];
  bit          e_st[MAXC];

  eu_fetch_sched #(.NUM_SUB(NS), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .fetch_mask     (fetch_mask),
    .base_addr      (base_addr),
    .stride         (stride),
    .sub_done       (sub_done),
    .eu_fetch       (eu_fetch),
    .eu_fetch_addr  (eu_fetch_addr),
    .sdram_read_sel (sdram_read_sel),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Builds the expected timeline for one sequence, then drives it open loop.
  // mode 0: clean, mode 1: random noise, mode 2: start re-pulsed every busy
  // cycle plus sub_done[5] throughout the wait on sub-unit 0.
  // Must be called at a negedge; that cycle becomes cycle 0 (start accepted).
  task automatic applyStimulus(input logic [7:0] mask, input logic [31:0] base,
                               input logic [31:0] strd, input int mode);
    int t, e, last_end, err_at, done_c;
    logic [31:0] a;
    for (int k = 0; k < MAXC; k++) begin
      e_fetch[k] = '0; e_addr[k] = '0; e_sel[k] = '0;
      e_act[k] = 0; e_busy[k] = 0; e_done[k] = 0; e_err[k] = 0; e_st[k] = 0;
      e_sd[k] = (mode == 1) ? 8'($urandom) : 8'h00;
    end
    t = 1; a = base; last_end = 0; err_at = -1;
    for (int i = 0; i < NS; i++) begin
      if (mask[i]) begin
        e = (dly[i] <= TO) ? t + dly[i] : t + TO;
        e_fetch[t] = 8'(1 << i);
        for (int k = t; k <= e; k++) begin
          e_act[k]  = 1;
          e_addr[k] = a;
          e_sel[k]  = 5'(i);
          if (k > t) begin
            e_sd[k][i] = 1'b0;
            if (mode == 2 && i == 0) e_sd[k][5] = 1'b1;
          end
        end
        if (t + dly[i] < MAXC) e_sd[t + dly[i]][i] = 1'b1;
        if (dly[i] > TO && err_at < 0) err_at = e + 1;
        a = a + strd;
        last_end = e;
        t = e + 1;
      end
    end
    done_c = (mask == 8'h00) ? 1 : last_end + 1;
    for (int k = 1; k <= done_c; k++) begin
      e_busy[k] = 1;
      if (mode == 2)      e_st[k] = 1;
      else if (mode == 1) e_st[k] = bit'($urandom_range(0, 1));
    end
    e_done[done_c] = 1;
    for (int k = 1; k < MAXC; k++) e_err[k] = (err_at >= 0) && (k >= err_at);

    start = 1'b1; fetch_mask = mask; base_addr = base; stride = strd; sub_done = e_sd[0];
    for (int k = 1; k <= done_c + 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("eu_fetch c%0d", k), 32'(eu_fetch), 32'(e_fetch[k]));
      checkOutput($sformatf("busy c%0d", k), 32'(busy), 32'(e_busy[k]));
      checkOutput($sformatf("done c%0d", k), 32'(done), 32'(e_done[k]));
      checkOutput($sformatf("err c%0d", k), 32'(err), 32'(e_err[k]));
      if (e_act[k]) begin
        checkOutput($sformatf("addr c%0d", k), eu_fetch_addr, e_addr[k]);
        checkOutput($sformatf("sel c%0d", k), 32'(sdram_read_sel), 32'(e_sel[k]));
      end
      start    = e_st[k];
      sub_done = e_sd[k];
      if (mode != 0) begin
        fetch_mask = 8'($urandom);
        base_addr  = $urandom;
        stride     = $urandom;
      end
    end
  endtask

  initial begin
    logic [7:0] m;
    rst = 1'b1; start = 1'b0; fetch_mask = '0; base_addr = '0; stride = '0; sub_done = '0;
    for (int i = 0; i < NS; i++) dly[i] = 3;
    repeat (3) @(negedge clk);
    checkOutput("reset eu_fetch", 32'(eu_fetch), 32'h0);
    checkOutput("reset addr", eu_fetch_addr, 32'h0);
    checkOutput("reset sel", 32'(sdram_read_sel), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset err", 32'(err), 32'h0);
    rst = 1'b0;

    $display("[TB] two-unit fetch with 3-cycle responses");
    applyStimulus(8'h05, 32'h0000_1000, 32'h40, 0);
    $display("[TB] empty mask");
    applyStimulus(8'h00, 32'h0000_2000, 32'h40, 0);
    $display("[TB] address wrap");
    dly[0] = 2; dly[1] = 2;
    applyStimulus(8'h03, 32'hFFFF_FFC0, 32'h40, 0);
    $display("[TB] timeout on sub-unit 1");
    dly[1] = 99; dly[2] = 3;
    applyStimulus(8'h06, 32'h0000_4000, 32'h100, 0);
    $display("[TB] start re-pulse and foreign sub_done ignored");
    for (int i = 0; i < NS; i++) dly[i] = 4;
    applyStimulus(8'h21, 32'h0000_5000, 32'h20, 2);
    $display("[TB] completion coinciding with timeout");
    dly[3] = 16;
    applyStimulus(8'h08, 32'h0000_6000, 32'h8, 0);

    $display("[TB] reset during WAIT");
    dly[0] = 99;
    start = 1'b1; fetch_mask = 8'h03; base_addr = 32'h2000; stride = 32'h4; sub_done = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("pre-reset busy", 32'(busy), 32'h1);
    checkOutput("pre-reset err", 32'(err), 32'h1);
    checkOutput("pre-reset sel", 32'(sdram_read_sel), 32'h1);
    checkOutput("pre-reset addr", eu_fetch_addr, 32'h2004);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset eu_fetch", 32'(eu_fetch), 32'h0);
    checkOutput("mid-reset addr", eu_fetch_addr, 32'h0);
    checkOutput("mid-reset sel", 32'(sdram_read_sel), 32'h0);
    checkOutput("mid-reset busy", 32'(busy), 32'h0);
    checkOutput("mid-reset done", 32'(done), 32'h0);
    checkOutput("mid-reset err", 32'(err), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < NS; i++) dly[i] = 3;
    applyStimulus(8'h01, 32'h0000_3000, 32'h10, 0);

    $display("[TB] random sequences");
    for (int s = 0; s < 12; s++) begin
      m = (s == 3) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < NS; i++) dly[i] = (s == 5) ? 16 : $urandom_range(1, 20);
      applyStimulus(m, $urandom, $urandom, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eu_fetch_sched.md
EU_FETCH_SCHED -- requirements
Module: eu_fetch_sched

Interface
REQ-001 SHALL have parameter NUM_SUB, default 8: number of EU sub-units sequenced; 1..32.
REQ-002 SHALL have parameter TIMEOUT, default 4096: maximum WAIT cycles per sub-unit; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse requesting a fetch sequence.
REQ-006 SHALL have port fetch_mask  input  NUM_SUB  sub-units to fetch; sampled when start is accepted.
REQ-007 SHALL have port base_addr  input  32  SDRAM address of the first fetch; sampled when start is accepted.
REQ-008 SHALL have port stride  input  32  address increment between successive fetches; sampled when start is accepted.
REQ-009 SHALL have port sub_done  input  NUM_SUB  per-sub-unit fetch-complete pulse.
REQ-010 SHALL have port eu_fetch  output  NUM_SUB  one-hot, one-cycle fetch command.
REQ-011 SHALL have port eu_fetch_addr  output  32  fetch address for the active sub-unit.
REQ-012 SHALL have port sdram_read_sel  output  5  SDRAM read-mux select, equal to the active sub-unit index.
REQ-013 SHALL have port busy  output  1  high while a sequence is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of a sequence.
REQ-015 SHALL have port err  output  1  sticky flag: a sub-unit timed out.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT and DONE.
REQ-017 IDLE: start accepted only here; latch pending=fetch_mask, addr=base_addr, stride, clear err; go to ISSUE if pending!=0, else DONE.
REQ-018 SHALL ignore start in any state other than IDLE; no latching, no state change.
REQ-019 ISSUE (exactly 1 cycle): idx = lowest set bit of pending; eu_fetch = 1<<idx for this cycle only; go to WAIT.
REQ-020 SHALL drive sdram_read_sel=idx and eu_fetch_addr=addr from ISSUE through the end of WAIT, both held stable.
REQ-021 WAIT: sample sub_done[idx] only; sub_done on other bits and sub_done during ISSUE/IDLE/DONE SHALL be ignored.
REQ-022 On sub_done[idx] in WAIT: clear pending[idx], addr = addr+stride modulo 2^32 (wraps, no flag); go to ISSUE if pending still !=0, else DONE.
REQ-023 SHALL count WAIT cycles in a wait counter reset on each ISSUE; if TIMEOUT!=0 and the counter reaches TIMEOUT with no sub_done[idx]: set err, then advance exactly as REQ-022.
REQ-024 If sub_done[idx] and the timeout coincide, SHALL count it as completion; err is not set.
REQ-025 DONE (exactly 1 cycle): done=1, then go to IDLE.
REQ-026 busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-027 Latency: start accepted in cycle 0 gives the first eu_fetch in cycle 1; sub_done in cycle n gives the next eu_fetch in cycle n+1; the last sub_done in cycle n gives done in cycle n+1.
REQ-028 Empty mask: start in cycle 0 gives done in cycle 1 with no eu_fetch issued.
REQ-029 err SHALL remain set until the next accepted start or reset.
REQ-030 Fetches SHALL be issued in ascending index order, each exactly once per sequence.

Reset
REQ-031 With rst high at a clock edge: state=IDLE, pending=0, counters=0, addr=0, eu_fetch=0, eu_fetch_addr=0, sdram_read_sel=0, busy=0, done=0, err=0.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no done pulse; start SHALL be accepted on the first cycle after rst deasserts.

Verification
REQ-033 Bench SHALL cover: mask=8'b0000_0101, base=0x1000, stride=0x40, sub_done 3 cycles after each fetch -> eu_fetch=0x01 @addr 0x1000 sel 0, then 0x04 @0x1040 sel 2, then done; err=0.
REQ-034 Bench SHALL cover: mask=0 -> done 1 cycle after start, busy high for 1 cycle, no eu_fetch.
REQ-035 Bench SHALL cover: base=0xFFFF_FFC0, stride=0x40, mask=0x03 -> second fetch addr 0x0000_0000.
REQ-036 Bench SHALL cover: TIMEOUT=16, sub-unit 1 never responds, mask=0x06 -> err set after 16 WAIT cycles, sub-unit 2 still fetched, done pulses, err held until the next start.
REQ-037 Bench SHALL cover: start re-pulsed while busy, plus sub_done[5] while waiting on idx 0 -> both ignored, sequence unchanged.
REQ-038 Bench SHALL cover: rst asserted during WAIT -> all outputs 0 the next cycle, no done; a new start is accepted immediately after rst deasserts.
